// File: rtl/frame_tx_11011_if.sv
// ---------------------------------------------------------------------------
// frame_tx_11011_if
// Purpose : bundles the payload handshake and serial-line signals of the
//           11011 frame transmitter.
// Signals : in_valid  source -> tx   payload word presented
//           in_data   source -> tx   payload word (DATA_W bits)
//           in_ready  tx -> source   transmitter can accept a word
//           out       tx -> line     serial line
//           out_valid tx -> line     out carries a frame bit this cycle
//           busy      tx -> source   frame in progress
//           done      tx -> source   one-cycle pulse after the last frame bit
// Modports: master = payload source / line sink, slave = transmitter.
// ---------------------------------------------------------------------------
interface frame_tx_11011_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out;
    logic              out_valid;
    logic              busy;
    logic              done;

    modport master (
        output in_valid, in_data,
        input  in_ready, out, out_valid, busy, done
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, out, out_valid, busy, done
    );
endinterface

// File: rtl/frame_tx_11011.sv
// ---------------------------------------------------------------------------
// frame_tx_11011
// Purpose : serial frame transmitter for the 11011 sync-word link. Accepts a
//           payload word over valid/ready, then sends the sync word 11011
//           followed by the payload MSB-first, one bit per clock.
// Ports   : clk   rising-edge clock
//           rstn  asynchronous active-low reset
//           bus   frame_tx_11011_if.slave (in_valid, in_data, in_ready,
//                 out, out_valid, busy, done)
// Options : define FRAME_TX_PARITY_EN to append an even-parity bit after
//           the payload LSB.
// All outputs come straight from flops; their next values are decoded from
// the next-state values so every output lines up with the state it reports.
// ---------------------------------------------------------------------------
module frame_tx_11011 #(
    parameter int                DATA_W = 8,
    parameter int                SYNC_W = 5,
    parameter logic [SYNC_W-1:0] SYNC   = 5'b11011
) (
    input  logic             clk,
    input  logic             rstn,
    frame_tx_11011_if.slave  bus
);
    localparam int MAX_W = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
    localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SYNC = 2'd1,
`ifdef FRAME_TX_PARITY_EN
        S_DATA = 2'd2,
        S_PAR  = 2'd3
`else
        S_DATA = 2'd2
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
`ifdef FRAME_TX_PARITY_EN
    logic               parity_q, parity_d;
`endif
    logic               out_q, out_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               in_ready_q, in_ready_d;

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
`ifdef FRAME_TX_PARITY_EN
        parity_d = parity_q;
`endif
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    state_d  = S_SYNC;
                    cnt_d    = CNT_W'(SYNC_W - 1);
                    shift_d  = bus.in_data;
`ifdef FRAME_TX_PARITY_EN
                    parity_d = ^bus.in_data;
`endif
                end
            end
            S_SYNC: begin
                if (cnt_q == '0) begin
                    state_d = S_DATA;
                    cnt_d   = CNT_W'(DATA_W - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DATA: begin
                // Shift so the next payload bit sits in the MSB.
                shift_d = shift_q << 1;
                if (cnt_q == '0) begin
`ifdef FRAME_TX_PARITY_EN
                    state_d = S_PAR;
`else
                    state_d = S_IDLE;
                    done_d  = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`ifdef FRAME_TX_PARITY_EN
            S_PAR: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
`endif
            default: begin
                // Illegal encoding: fall back to idle with reset contents.
                state_d = S_IDLE;
                cnt_d   = '0;
                shift_d = '0;
            end
        endcase
    end

    // Output decode from next-state values, registered below.
    always_comb begin
        out_d       = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        in_ready_d  = 1'b1;
        case (state_d)
            S_SYNC: begin
                out_d       = SYNC[cnt_d];
                out_valid_d = 1'b1;
                busy_d      = 1'b1;
                in_ready_d  = 1'b0;
            end
            S_DATA: begin
                out_d       = shift_d[DATA_W-1];
                out_valid_d = 1'b1;
                busy_d      = 1'b1;
                in_ready_d  = 1'b0;
            end
`ifdef FRAME_TX_PARITY_EN
            S_PAR: begin
                out_d       = parity_d;
                out_valid_d = 1'b1;
                busy_d      = 1'b1;
                in_ready_d  = 1'b0;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
`ifdef FRAME_TX_PARITY_EN
            parity_q    <= 1'b0;
`endif
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
`ifdef FRAME_TX_PARITY_EN
            parity_q    <= parity_d;
`endif
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.in_ready  = in_ready_q;
endmodule

// File: tb/tb_frame_tx_11011.sv
// ---------------------------------------------------------------------------
// tb_frame_tx_11011
// Testbench for frame_tx_11011. Expected serial bits are pushed to a queue
// when a word is offered and popped as the DUT emits frame bits. A model of
// the downstream 11011 detector runs on the line. Honours FRAME_TX_PARITY_EN.
// ---------------------------------------------------------------------------
module tb_frame_tx_11011;
    localparam int DW = 8;
    localparam int SW = 5;
`ifdef FRAME_TX_PARITY_EN
    localparam int FL = SW + DW + 1;
`else
    localparam int FL = SW + DW;
`endif

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    frame_tx_11011_if #(.DATA_W(DW)) bus ();

    frame_tx_11011 #(.DATA_W(DW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int       n_vec = 0;
    int       n_err = 0;
    logic     exp_q[$];
    logic     exp_bit;
    logic [4:0] det_q;

    // Expected frame: sync word MSB-first, payload MSB-first, optional parity.
    function automatic void push_frame(input logic [DW-1:0] w);
        logic [SW-1:0] s;
        s = 5'b11011;
        for (int i = SW - 1; i >= 0; i--) exp_q.push_back(s[i]);
        for (int i = DW - 1; i >= 0; i--) exp_q.push_back(w[i]);
`ifdef FRAME_TX_PARITY_EN
        exp_q.push_back(^w);
`endif
    endfunction

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (bus.out !== 1'b0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.done !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_values: out=%b ov=%b busy=%b done=%b rdy=%b, want 0 0 0 0 1",
                     bus.out, bus.out_valid, bus.busy, bus.done, bus.in_ready);
        end
        rstn = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_vec++;
            if (bus.out !== 1'b0 || bus.out_valid !== 1'b0 || bus.done !== 1'b0 ||
                bus.in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL idle_cycle%0d: out=%b ov=%b done=%b rdy=%b, want 0 0 0 1",
                         c, bus.out, bus.out_valid, bus.done, bus.in_ready);
            end
        end
        $display("reset + 10 idle cycles checked");
    endtask

    // One word, one-cycle in_valid; optionally corrupt in_data after acceptance.
    task automatic test_frame(input logic [DW-1:0] w, input bit mutate);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        push_frame(w);
        det_q = '0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        if (mutate) bus.in_data = '0;
        for (int i = 0; i < FL; i++) begin
            if (i > 0) @(negedge clk);
            exp_bit = exp_q.pop_front();
            det_q   = {det_q[3:0], bus.out};
            n_vec++;
            if (bus.out !== exp_bit || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                n_err++;
                $display("FAIL frame_%h_bit%0d: out=%b ov=%b rdy=%b busy=%b done=%b, want out=%b ov=1 rdy=0 busy=1 done=0",
                         w, i, bus.out, bus.out_valid, bus.in_ready, bus.busy, bus.done, exp_bit);
            end
            n_vec++;
            if ((det_q == 5'b11011) !== (i == SW - 1)) begin
                n_err++;
                $display("FAIL detect_%h_bit%0d: detector=%b, want %b",
                         w, i, (det_q == 5'b11011), (i == SW - 1));
            end
        end
        @(negedge clk);
        n_vec++;
        if (bus.done !== 1'b1 || bus.out !== 1'b0 || bus.out_valid !== 1'b0 ||
            bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL done_%h: done=%b out=%b ov=%b rdy=%b busy=%b, want 1 0 0 1 0",
                     w, bus.done, bus.out, bus.out_valid, bus.in_ready, bus.busy);
        end
        @(negedge clk);
        n_vec++;
        if (bus.done !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL done_pulse_%h: done=%b ov=%b, want 0 0", w, bus.done, bus.out_valid);
        end
        $display("frame word=%h mutate=%0d: %0d bits checked", w, mutate, FL);
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] words [2];
        words[0] = 8'h0F;
        words[1] = 8'hF0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = words[0];
        push_frame(words[0]);
        push_frame(words[1]);
        @(negedge clk);
        // in_valid stays high; the next word waits for in_ready.
        bus.in_data = words[1];
        for (int f = 0; f < 2; f++) begin
            det_q = '0;
            for (int i = 0; i < FL; i++) begin
                if (i > 0) @(negedge clk);
                exp_bit = exp_q.pop_front();
                det_q   = {det_q[3:0], bus.out};
                n_vec++;
                if (bus.out !== exp_bit || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL b2b_f%0d_bit%0d: out=%b ov=%b rdy=%b, want out=%b ov=1 rdy=0",
                             f, i, bus.out, bus.out_valid, bus.in_ready, exp_bit);
                end
                n_vec++;
                if ((det_q == 5'b11011) !== (i == SW - 1)) begin
                    n_err++;
                    $display("FAIL b2b_detect_f%0d_bit%0d: detector=%b, want %b",
                             f, i, (det_q == 5'b11011), (i == SW - 1));
                end
            end
            @(negedge clk);
            n_vec++;
            if (bus.done !== 1'b1 || bus.out !== 1'b0 || bus.out_valid !== 1'b0 ||
                bus.in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_gap_f%0d: done=%b out=%b ov=%b rdy=%b, want 1 0 0 1",
                         f, bus.done, bus.out, bus.out_valid, bus.in_ready);
            end
            if (f == 0) begin
                // Second word is accepted at the edge ending the done cycle.
                @(negedge clk);
                bus.in_valid = 1'b0;
            end
        end
        @(negedge clk);
        n_vec++;
        if (bus.out_valid !== 1'b0 || bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_end: ov=%b done=%b, want 0 0", bus.out_valid, bus.done);
        end
        $display("back-to-back frames 0F,F0 checked");
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        push_frame(8'hFF);
        @(negedge clk);
        bus.in_valid = 1'b0;
        // Run up to and including payload bit 3 (MSB is bit 0).
        for (int i = 0; i <= SW + 3; i++) begin
            if (i > 0) @(negedge clk);
            exp_bit = exp_q.pop_front();
            n_vec++;
            if (bus.out !== exp_bit || bus.out_valid !== 1'b1) begin
                n_err++;
                $display("FAIL abort_bit%0d: out=%b ov=%b, want out=%b ov=1",
                         i, bus.out, bus.out_valid, exp_bit);
            end
        end
        exp_q.delete();
        #2 rstn = 1'b0;
        #1;
        n_vec++;
        if (bus.out !== 1'b0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.done !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL async_reset: out=%b ov=%b busy=%b done=%b rdy=%b, want 0 0 0 0 1",
                     bus.out, bus.out_valid, bus.busy, bus.done, bus.in_ready);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        saw_done = 1'b0;
        for (int c = 0; c < FL + 4; c++) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.out_valid !== 1'b0) saw_done = 1'b1;
        end
        n_vec++;
        if (saw_done) begin
            n_err++;
            $display("FAIL post_abort_idle: activity=%b, want 0", saw_done);
        end
        $display("reset during payload bit 3 of FF checked");
        test_frame(8'h3C, 1'b0);
    endtask

    initial begin
        test_reset();
        test_frame(8'hA5, 1'b0);
        test_frame(8'h01, 1'b0);
        test_back_to_back();
        test_reset_mid();
        test_frame(8'hC3, 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
